// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX frame arbiter.
// The TAG state is only reachable when UART_ARB_TAG_EN is defined.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    SEND = 2'd2
  } arb_state_e;

  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  // Wrap explicitly so non-power-of-2 client counts rotate correctly.
  function automatic int next_rr(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request at or above ptr, modulo N_CLIENTS.
module rr_pick #(
  parameter int N_CLIENTS = 4
) (
  input  logic [N_CLIENTS-1:0]         req,
  input  logic [$clog2(N_CLIENTS)-1:0] ptr,
  output logic [$clog2(N_CLIENTS)-1:0] idx,
  output logic                         any
);
  localparam int IW = $clog2(N_CLIENTS);

  logic [IW:0] cand;

  // Walk offsets from highest to lowest so the nearest-to-ptr hit wins.
  always_comb begin
    idx  = '0;
    any  = |req;
    cand = '0;
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_CLIENTS)) cand = cand - (IW+1)'(N_CLIENTS);
      if (req[cand[IW-1:0]]) idx = cand[IW-1:0];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter in front of the UART TX FIFO write port.
// Define UART_ARB_TAG_EN to prefix each frame with an {A, client id} header byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_CLIENTS     = 4,
  parameter int DBIT          = 8,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_CLIENTS-1:0]         req_valid,
  input  logic [N_CLIENTS*DBIT-1:0]    req_data,
  input  logic [N_CLIENTS-1:0]         req_last,
  output logic [N_CLIENTS-1:0]         req_ready,
  input  logic                         tx_full,
  output logic                         wr_uart,
  output logic [DBIT-1:0]              w_data,
  output logic [$clog2(N_CLIENTS)-1:0] grant_id,
  output logic                         busy,
  output logic                         stall_abort
);
  localparam int IW = $clog2(N_CLIENTS);
  localparam int CW = $clog2(STALL_TIMEOUT);
  localparam logic [CW-1:0] STALL_MAX = CW'(STALL_TIMEOUT - 1);

`ifdef UART_ARB_TAG_EN
  localparam arb_state_e GRANT_ST = TAG;
`else
  localparam arb_state_e GRANT_ST = SEND;
`endif

  arb_state_e state, state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] stall_cnt;

  logic [N_CLIENTS-1:0][DBIT-1:0] req_bytes;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          sel_valid, sel_last, xfer, stall_hit, frame_end;
  logic [DBIT-1:0] sel_data;

  assign req_bytes = req_data;
  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign sel_data  = req_bytes[grant_id];

  rr_pick #(.N_CLIENTS(N_CLIENTS)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Back-pressure from tx_full never advances the watchdog; only a missing byte does.
  assign stall_hit = (state == SEND) & ~sel_valid & (stall_cnt == STALL_MAX);
  assign frame_end = (xfer & sel_last) | stall_hit;
  assign busy      = (state != IDLE);

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_ready
    assign req_ready[i] = xfer & (grant_id == IW'(i));
  end

  always_comb begin
    state_nxt = state;
    wr_uart   = 1'b0;
    w_data    = '0;
    xfer      = 1'b0;
    case (state)
      IDLE: if (pick_any) state_nxt = GRANT_ST;
`ifdef UART_ARB_TAG_EN
      TAG: if (!tx_full) begin
        wr_uart   = 1'b1;
        w_data    = {TAG_NIBBLE, (DBIT-4)'(grant_id)};
        state_nxt = SEND;
      end
`endif
      SEND: begin
        xfer    = sel_valid & ~tx_full;
        wr_uart = xfer;
        w_data  = sel_data;
        if (frame_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      stall_cnt   <= '0;
      stall_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      stall_abort <= stall_hit;
      if (state == IDLE && pick_any) grant_id <= pick_idx;
      if (frame_end) rr_ptr <= IW'(next_rr(int'(grant_id), N_CLIENTS));
      if (state == SEND && !sel_valid && !stall_hit) stall_cnt <= stall_cnt + 1'b1;
      else                                           stall_cnt <= '0;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single write port of the UART core (wr_uart / w_data / tx_full) among N byte-stream clients.
- Round-robin arbitration at frame granularity. A grant is held from a client's first byte to its req_last byte, so frames never interleave on the serial line.
- Sits between the system-side requesters (CPU bridge, debug monitor, status streamer) and the UART TX FIFO.
- A watchdog releases a grant held by a client that stalls mid-frame.

Parameters:
N_CLIENTS, 4, number of requesting clients (2..8)
DBIT, 8, data byte width; matches the UART DBIT
STALL_TIMEOUT, 1024, cycles a granted client may hold req_valid low mid-frame before forced release (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  N_CLIENTS  per-client byte valid
req_data  in  N_CLIENTS*DBIT  per-client byte; client i occupies bits [i*DBIT +: DBIT]
req_last  in  N_CLIENTS  per-client marker: current byte ends the frame
req_ready  out  N_CLIENTS  per-client byte accepted this cycle (one-hot or zero)
tx_full  in  1  UART TX FIFO full
wr_uart  out  1  UART TX FIFO write strobe
w_data  out  DBIT  byte to UART TX FIFO
grant_id  out  $clog2(N_CLIENTS)  currently/last granted client index
busy  out  1  a frame is in progress (state != IDLE)
stall_abort  out  1  one-cycle pulse when the watchdog releases a grant

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, stall counter=0, busy=0, stall_abort=0. Combinational outputs evaluate to wr_uart=0, req_ready=0, w_data=0 in IDLE.
- Registered state machine: IDLE, SEND.
- IDLE:
  - If any req_valid is set, select the first set bit searching from rr_ptr upward, modulo N_CLIENTS.
  - Register grant_id and go to SEND next cycle. No byte is accepted in IDLE, so there is 1 cycle of arbitration latency.
- SEND:
  - Handshake (combinational): xfer = req_valid[grant_id] & ~tx_full.
  - wr_uart = xfer; w_data = req_data[grant_id]; req_ready[grant_id] = xfer; all other req_ready bits are 0.
  - A byte transfers only when valid and ~tx_full are high in the same cycle. Clients must hold data stable while valid & ~ready.
  - On xfer & req_last[grant_id]: go to IDLE and set rr_ptr = grant_id+1, wrapping to 0 after N_CLIENTS-1. Back-to-back frames from different clients are separated by one IDLE cycle.
- Watchdog:
  - In SEND, the stall counter increments each cycle req_valid[grant_id]=0 and clears on any cycle it is 1.
  - tx_full back-pressure does not count as a stall.
  - When the counter reaches STALL_TIMEOUT-1 with valid still low: pulse stall_abort for 1 cycle, go to IDLE, advance rr_ptr past the offender, clear the counter.
- Boundary conditions:
  - tx_full held high: stay in SEND indefinitely with wr_uart=0; no timeout.
  - Single client requesting repeatedly: it is re-granted after each IDLE cycle.
  - req_valid of a non-granted client is ignored, with its ready=0, until arbitration.
  - req_last on a byte that does not transfer has no effect.
  - Reset asserted mid-frame: immediate return to reset values. The partial frame already in the FIFO is not recalled.
- Width rule: the rr_ptr/grant_id increment wraps explicitly at N_CLIENTS; non-power-of-2 N_CLIENTS is legal.

Optional Feature:
- Macro: UART_ARB_TAG_EN.
- When defined:
  - Add state TAG between IDLE and SEND.
  - In TAG, when ~tx_full: wr_uart=1, w_data = {4'hA, grant_id zero-extended to DBIT-4}, e.g. client 2 gives 8'hA2. Then go to SEND.
  - No req_ready is asserted in TAG. The watchdog is inactive in TAG.
  - The receiver can demultiplex frames by this header.
- When undefined: no TAG state; frames are sent untagged, exactly as above.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum typedef {IDLE, TAG, SEND}; TAG is present but unused without the macro.
  - localparam TAG_NIBBLE = 4'hA.
  - function next_rr(ptr, n) for the wrap-around increment.
- Sub-module rr_pick (N_CLIENTS): combinational rotate-priority encoder with inputs req, ptr and outputs idx, any.

Test Plan:
- Reset, then client 1 sends a 3-byte frame 8'h11, 8'h12, 8'h13 (last on 8'h13) with tx_full=0 -> grant_id=1 one cycle after valid; three wr_uart pulses in consecutive cycles with those bytes; busy drops the cycle after 8'h13; rr_ptr=2.
- Clients 0 and 2 both valid with 2-byte frames (0: 8'h01, 8'h02; 2: 8'h21, 8'h22), rr_ptr=0 -> FIFO sees 01, 02, 21, 22 with no interleave; client 2's req_ready stays 0 until client 0's last byte.
- tx_full=1 for 2000 cycles while client 3 is granted and valid -> no wr_uart, no stall_abort. Release tx_full -> byte written the next cycle.
- Client 0 granted, sends 1 byte without last, then drops valid -> stall_abort after STALL_TIMEOUT cycles; state IDLE; a pending client 1 is granted on the following arbitration.
- reset_n pulsed low mid-frame of client 2 -> outputs at reset values asynchronously; after release, client 0 is granted first (rr_ptr=0).
- With UART_ARB_TAG_EN, client 2 sends 8'h55 (last) -> FIFO sees 8'hA2 then 8'h55; req_ready[2] asserted only on 8'h55.
